// File: rtl/mpu_pkg.sv
// Shared types and constants for the conv_ctrl -> mpu_ctrl command bus.
package mpu_pkg;

   localparam int MRX_IND_W  = 5;
   localparam int MRX_ADDR_W = 9;
   localparam int VR_IND_W   = 4;
   localparam int MAC_LEN_W  = 7;
   localparam int REP_W      = 8;

   localparam logic [1:0] MPU_CODE_MMUL = 2'd1;
   localparam logic [1:0] MPU_CODE_MMAC = 2'd3;

   localparam int EN_ACT = 0;
   localparam int EN_MAC = 1;

   localparam logic MPU_TYPE_MM = 1'b0;
   localparam logic MPU_TYPE_VM = 1'b1;

   typedef struct packed {
      logic [1:0]            code;
      logic                  typ;
      logic                  mpu0_sl;
      logic                  mpu0_sr;
      logic                  mpu1_sl;
      logic                  mpu1_sr;
      logic [MRX_IND_W-1:0]  mpu0_index;
      logic [MRX_IND_W-1:0]  mpu1_index;
      logic [MRX_IND_W-1:0]  mrs1_index;
      logic [MRX_ADDR_W-1:0] mpu0_addr;
      logic [MRX_ADDR_W-1:0] mpu1_addr;
      logic [MRX_ADDR_W-1:0] mrs1_addr;
      logic [MRX_ADDR_W-1:0] stride;
      logic [VR_IND_W-1:0]   vrd_index;
      logic [MAC_LEN_W-1:0]  mac_len;
      logic [REP_W-1:0]      rep;
   } mpu_desc_t;

   function automatic logic desc_legal(mpu_desc_t d);
      return ((d.code == MPU_CODE_MMUL) || (d.code == MPU_CODE_MMAC))
          && (d.rep != '0)
          && !(d.code[EN_MAC] && (d.mac_len == '0));
   endfunction

endpackage

// File: rtl/mpu_cmd_issuer.sv
// Expands matrix-op descriptors into MMAC/MMUL commands on the
// convctl_mpu bus, holding each for its execution window.
module mpu_cmd_issuer
   import mpu_pkg::*;
#(
   parameter int MRX_IND_WTH  = 5,
   parameter int MRX_ADDR_WTH = 9,
   parameter int VR_IND_WTH   = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    desc_valid_i,
   output logic                    desc_ready_o,
   input  logic [1:0]              desc_code_i,
   input  logic                    desc_type_i,
   input  logic                    desc_mpu0_sl_i,
   input  logic                    desc_mpu0_sr_i,
   input  logic                    desc_mpu1_sl_i,
   input  logic                    desc_mpu1_sr_i,
   input  logic [MRX_IND_WTH-1:0]  desc_mpu0_index_i,
   input  logic [MRX_IND_WTH-1:0]  desc_mpu1_index_i,
   input  logic [MRX_IND_WTH-1:0]  desc_mrs1_index_i,
   input  logic [MRX_ADDR_WTH-1:0] desc_mpu0_addr_i,
   input  logic [MRX_ADDR_WTH-1:0] desc_mpu1_addr_i,
   input  logic [MRX_ADDR_WTH-1:0] desc_mrs1_addr_i,
   input  logic [MRX_ADDR_WTH-1:0] desc_stride_i,
   input  logic [VR_IND_WTH-1:0]   desc_vrd_index_i,
   input  logic [6:0]              desc_mac_len_i,
   input  logic [7:0]              desc_rep_i,
   output logic [1:0]              convctl_mpu__code_o,
   output logic                    convctl_mpu__type_o,
   output logic                    convctl_mpu0__mrs0_sl_o,
   output logic                    convctl_mpu0__mrs0_sr_o,
   output logic [MRX_IND_WTH-1:0]  convctl_mpu0__mrs0_index_o,
   output logic [MRX_ADDR_WTH-1:0] convctl_mpu0__mrs0_addr_o,
   output logic                    convctl_mpu1__mrs0_sl_o,
   output logic                    convctl_mpu1__mrs0_sr_o,
   output logic [MRX_IND_WTH-1:0]  convctl_mpu1__mrs0_index_o,
   output logic [MRX_ADDR_WTH-1:0] convctl_mpu1__mrs0_addr_o,
   output logic [MRX_IND_WTH-1:0]  convctl_mpu__mrs1_index_o,
   output logic [MRX_ADDR_WTH-1:0] convctl_mpu__mrs1_addr_o,
   output logic [VR_IND_WTH-1:0]   convctl_mpu__vrd_index_o,
   output logic [6:0]              convctl_mpu__mac_len_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o
);

   typedef enum logic {S_IDLE, S_ISSUE} state_e;

   state_e          state_q, state_d;
   mpu_desc_t       cmd_q, cmd_d, desc_in;
   logic [6:0]      win_cnt_q, win_cnt_d;
   logic [VR_IND_WTH-1:0] vrd_lag_q, vrd_lag_d;
   logic [6:0]      len_lag_q, len_lag_d;
   logic            err_q, err_d;
   logic            issuing, last_win, last_rep, fin, accept;

   always_comb begin
      desc_in            = '0;
      desc_in.code       = desc_code_i;
      desc_in.typ        = desc_type_i;
      desc_in.mpu0_sl    = desc_mpu0_sl_i;
      desc_in.mpu0_sr    = desc_mpu0_sr_i;
      desc_in.mpu1_sl    = desc_mpu1_sl_i;
      desc_in.mpu1_sr    = desc_mpu1_sr_i;
      desc_in.mpu0_index = desc_mpu0_index_i;
      desc_in.mpu1_index = desc_mpu1_index_i;
      desc_in.mrs1_index = desc_mrs1_index_i;
      desc_in.mpu0_addr  = desc_mpu0_addr_i;
      desc_in.mpu1_addr  = desc_mpu1_addr_i;
      desc_in.mrs1_addr  = desc_mrs1_addr_i;
      desc_in.stride     = desc_stride_i;
      desc_in.vrd_index  = desc_vrd_index_i;
      desc_in.mac_len    = desc_mac_len_i;
      desc_in.rep        = desc_rep_i;
   end

   // cmd_q.rep holds the reps still to go after the current one
   always_comb begin
      issuing      = (state_q == S_ISSUE);
      last_win     = issuing && (!cmd_q.code[EN_MAC] ||
                     (win_cnt_q == cmd_q.mac_len - 7'd1));
      last_rep     = (cmd_q.rep == '0);
      fin          = last_win && last_rep;
      desc_ready_o = !issuing || fin;
      done_o       = fin;
      accept       = desc_valid_i && desc_ready_o;

      state_d   = state_q;
      cmd_d     = cmd_q;
      win_cnt_d = win_cnt_q;
      err_d     = 1'b0;

      if (issuing) begin
         if (!last_win) begin
            win_cnt_d = win_cnt_q + 7'd1;
         end else if (!last_rep) begin
            win_cnt_d       = '0;
            cmd_d.rep       = cmd_q.rep - 8'd1;
            cmd_d.mpu0_addr = cmd_q.mpu0_addr + cmd_q.stride;
            cmd_d.mpu1_addr = cmd_q.mpu1_addr + cmd_q.stride;
            cmd_d.vrd_index = cmd_q.vrd_index + 4'd1;
         end else begin
            state_d   = S_IDLE;
            cmd_d     = '0;
            win_cnt_d = '0;
         end
      end

      if (accept) begin
         if (desc_legal(desc_in)) begin
            state_d   = S_ISSUE;
            cmd_d     = desc_in;
            cmd_d.rep = desc_in.rep - 8'd1;
            win_cnt_d = '0;
         end else begin
            err_d = 1'b1;
         end
      end

      vrd_lag_d = vrd_lag_q;
      len_lag_d = len_lag_q;
      if (issuing && (win_cnt_q == '0)) begin
         vrd_lag_d = cmd_q.vrd_index;
         len_lag_d = cmd_q.mac_len;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         cmd_q     <= '0;
         win_cnt_q <= '0;
         vrd_lag_q <= '0;
         len_lag_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         win_cnt_q <= win_cnt_d;
         vrd_lag_q <= vrd_lag_d;
         len_lag_q <= len_lag_d;
         err_q     <= err_d;
      end
   end

   assign convctl_mpu__code_o        = cmd_q.code;
   assign convctl_mpu__type_o        = cmd_q.typ;
   assign convctl_mpu0__mrs0_sl_o    = cmd_q.mpu0_sl;
   assign convctl_mpu0__mrs0_sr_o    = cmd_q.mpu0_sr;
   assign convctl_mpu0__mrs0_index_o = cmd_q.mpu0_index;
   assign convctl_mpu0__mrs0_addr_o  = cmd_q.mpu0_addr;
   assign convctl_mpu1__mrs0_sl_o    = cmd_q.mpu1_sl;
   assign convctl_mpu1__mrs0_sr_o    = cmd_q.mpu1_sr;
   assign convctl_mpu1__mrs0_index_o = cmd_q.mpu1_index;
   assign convctl_mpu1__mrs0_addr_o  = cmd_q.mpu1_addr;
   assign convctl_mpu__mrs1_index_o  = cmd_q.mrs1_index;
   assign convctl_mpu__mrs1_addr_o   = cmd_q.mrs1_addr;
   assign convctl_mpu__vrd_index_o   = vrd_lag_q;
   assign convctl_mpu__mac_len_o     = len_lag_q;
   assign busy_o                     = issuing;
   assign err_o                      = err_q;

endmodule

// File: tb/tb_mpu_cmd_issuer.sv
// Randomized + directed bench for mpu_cmd_issuer against a
// per-cycle frame-schedule reference model.
module tb_mpu_cmd_issuer;
   import mpu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       d_valid;
   mpu_desc_t  d;
   logic       ready, busy, done, err;
   logic [1:0] code;
   logic       typ, s0l, s0r, s1l, s1r;
   logic [4:0] i0, i1, im;
   logic [8:0] a0, a1, am;
   logic [3:0] vrd;
   logic [6:0] len;

   mpu_cmd_issuer dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .desc_valid_i(d_valid), .desc_ready_o(ready),
      .desc_code_i(d.code), .desc_type_i(d.typ),
      .desc_mpu0_sl_i(d.mpu0_sl), .desc_mpu0_sr_i(d.mpu0_sr),
      .desc_mpu1_sl_i(d.mpu1_sl), .desc_mpu1_sr_i(d.mpu1_sr),
      .desc_mpu0_index_i(d.mpu0_index),
      .desc_mpu1_index_i(d.mpu1_index),
      .desc_mrs1_index_i(d.mrs1_index),
      .desc_mpu0_addr_i(d.mpu0_addr),
      .desc_mpu1_addr_i(d.mpu1_addr),
      .desc_mrs1_addr_i(d.mrs1_addr),
      .desc_stride_i(d.stride), .desc_vrd_index_i(d.vrd_index),
      .desc_mac_len_i(d.mac_len), .desc_rep_i(d.rep),
      .convctl_mpu__code_o(code), .convctl_mpu__type_o(typ),
      .convctl_mpu0__mrs0_sl_o(s0l), .convctl_mpu0__mrs0_sr_o(s0r),
      .convctl_mpu0__mrs0_index_o(i0),
      .convctl_mpu0__mrs0_addr_o(a0),
      .convctl_mpu1__mrs0_sl_o(s1l), .convctl_mpu1__mrs0_sr_o(s1r),
      .convctl_mpu1__mrs0_index_o(i1),
      .convctl_mpu1__mrs0_addr_o(a1),
      .convctl_mpu__mrs1_index_o(im), .convctl_mpu__mrs1_addr_o(am),
      .convctl_mpu__vrd_index_o(vrd), .convctl_mpu__mac_len_o(len),
      .busy_o(busy), .done_o(done), .err_o(err)
   );

   typedef struct {
      logic [1:0] code;
      logic       typ;
      logic [3:0] flags;
      logic [14:0] idx;
      logic [8:0] a0, a1, am;
      logic [3:0] vrd;
      logic [6:0] len;
      bit         first, last;
   } frame_t;

   frame_t fq[$];
   logic   exp_err;
   logic [3:0] lag_vrd;
   logic [6:0] lag_len;
   int n_chk, n_pass;
   int cyc;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
   endtask

   function automatic bit legal(mpu_desc_t x);
      return (x.code == 2'd1 || x.code == 2'd3) && x.rep != 0 &&
             !(x.code == 2'd3 && x.mac_len == 0);
   endfunction

   task automatic expand(input mpu_desc_t x);
      int win;
      frame_t f;
      win = (x.code == 2'd3) ? int'(x.mac_len) : 1;
      for (int r = 0; r < int'(x.rep); r++)
         for (int w = 0; w < win; w++) begin
            f.code  = x.code;
            f.typ   = x.typ;
            f.flags = {x.mpu0_sl, x.mpu0_sr, x.mpu1_sl, x.mpu1_sr};
            f.idx   = {x.mpu0_index, x.mpu1_index, x.mrs1_index};
            f.a0    = 9'(int'(x.mpu0_addr) + r * int'(x.stride));
            f.a1    = 9'(int'(x.mpu1_addr) + r * int'(x.stride));
            f.am    = x.mrs1_addr;
            f.vrd   = 4'(int'(x.vrd_index) + r);
            f.len   = x.mac_len;
            f.first = (w == 0);
            f.last  = (r == int'(x.rep) - 1) && (w == win - 1);
            fq.push_back(f);
         end
   endtask

   task automatic check_outputs();
      frame_t f;
      bit act;
      act = (fq.size() > 0);
      if (act) f = fq[0];
      else begin
         f.code = 0; f.typ = 0; f.flags = 0; f.idx = 0;
         f.a0 = 0; f.a1 = 0; f.am = 0; f.vrd = 0; f.len = 0;
         f.first = 0; f.last = 0;
      end
      chk("code", 32'(code), 32'(f.code));
      chk("type", 32'(typ), 32'(f.typ));
      chk("flags", 32'({s0l, s0r, s1l, s1r}), 32'(f.flags));
      chk("idx", 32'({i0, i1, im}), 32'(f.idx));
      chk("mpu0_addr", 32'(a0), 32'(f.a0));
      chk("mpu1_addr", 32'(a1), 32'(f.a1));
      chk("mrs1_addr", 32'(am), 32'(f.am));
      chk("vrd_lag", 32'(vrd), 32'(lag_vrd));
      chk("len_lag", 32'(len), 32'(lag_len));
      chk("busy", 32'(busy), 32'(act));
      chk("done", 32'(done), 32'(act && f.last));
      chk("ready", 32'(ready), 32'(!act || f.last));
      chk("err", 32'(err), 32'(exp_err));
   endtask

   task automatic model_step(input logic v, input mpu_desc_t x);
      bit acc;
      acc = v && (fq.size() == 0 || fq[0].last);
      if (fq.size() > 0) begin
         if (fq[0].first) begin
            lag_vrd = fq[0].vrd;
            lag_len = fq[0].len;
         end
         void'(fq.pop_front());
      end
      exp_err = acc && !legal(x);
      if (acc && legal(x)) expand(x);
   endtask

   task automatic tick(input logic v, input mpu_desc_t x);
      @(negedge clk);
      cyc++;
      check_outputs();
      d_valid = v;
      d = x;
      model_step(v, x);
   endtask

   task automatic model_reset();
      fq.delete();
      exp_err = 0;
      lag_vrd = 0;
      lag_len = 0;
   endtask

   function automatic mpu_desc_t mk(input logic [1:0] c, input logic [6:0] l,
                                    input logic [7:0] r, input logic [8:0] a,
                                    input logic [8:0] s, input logic [3:0] v);
      mpu_desc_t x;
      x = '0;
      x.code = c; x.mac_len = l; x.rep = r;
      x.mpu0_addr = a; x.mpu1_addr = a + 9'h40;
      x.mrs1_addr = 9'h20; x.stride = s; x.vrd_index = v;
      x.typ = 1'b1; x.mpu0_sl = 1'b1; x.mpu1_sr = 1'b1;
      x.mpu0_index = 5'd7; x.mpu1_index = 5'd9; x.mrs1_index = 5'd2;
      return x;
   endfunction

   function automatic mpu_desc_t rnd();
      mpu_desc_t x;
      int k;
      x = mpu_desc_t'({$urandom, $urandom, $urandom});
      k = int'($urandom_range(0, 7));
      x.code = (k == 0) ? 2'd0 : (k == 1) ? 2'd2 :
               (k < 5) ? 2'd1 : 2'd3;
      x.mac_len = 7'($urandom_range(0, 5));
      x.rep = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
      return x;
   endfunction

   mpu_desc_t z;

   initial begin
      n_chk = 0; n_pass = 0; cyc = 0;
      z = '0;
      d = '0;
      d_valid = 0;
      model_reset();
      #12;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_code", 32'(code), 32'd0);
      rst_n = 1;

      tick(0, z);
      // single MMAC, then wrap, repeated MMUL, back-to-back
      tick(1, mk(2'd3, 7'd4, 8'd1, 9'h010, 9'd0, 4'd3));
      repeat (7) tick(0, z);
      tick(1, mk(2'd3, 7'd2, 8'd3, 9'h1FE, 9'd2, 4'd14));
      repeat (8) tick(0, z);
      tick(1, mk(2'd1, 7'd0, 8'd4, 9'h033, 9'd5, 4'd0));
      repeat (6) tick(0, z);
      tick(1, mk(2'd3, 7'd1, 8'd1, 9'h005, 9'd1, 4'd6));
      tick(1, mk(2'd1, 7'd9, 8'd1, 9'h0AA, 9'd1, 4'd8));
      repeat (4) tick(0, z);
      // illegal: bad code, then MMAC with zero length
      tick(1, mk(2'd2, 7'd3, 8'd1, 9'h001, 9'd1, 4'd1));
      tick(0, z);
      tick(1, mk(2'd3, 7'd0, 8'd2, 9'h001, 9'd1, 4'd1));
      repeat (3) tick(0, z);

      // reset during rep 2 of 3
      tick(1, mk(2'd3, 7'd3, 8'd3, 9'h100, 9'd8, 4'd5));
      repeat (4) tick(0, z);
      #3 rst_n = 0;
      #1;
      chk("arst_code", 32'(code), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_addr", 32'(a0), 32'd0);
      chk("arst_vrd", 32'(vrd), 32'd0);
      chk("arst_len", 32'(len), 32'd0);
      chk("arst_ready", 32'(ready), 32'd1);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      repeat (3) tick(0, z);
      tick(1, mk(2'd3, 7'd2, 8'd2, 9'h0F0, 9'd4, 4'd1));
      repeat (6) tick(0, z);

      for (int i = 0; i < 600; i++)
         tick(($urandom_range(0, 2) != 0), rnd());
      repeat (40) tick(0, z);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mpu_cmd_issuer.md
# mpu_cmd_issuer

Command issuer on the conv_ctrl side of the MPU command interface. It accepts matrix-operation descriptors over a valid/ready handshake, expands each into one or more MMAC/MMUL commands, and drives them onto the `convctl_mpu*` bus consumed by `mpu_ctrl`. That bus has no backpressure, so the issuer itself enforces the window timing `mpu_ctrl` expects: it holds each command for exactly its execution window and issues back-to-back with no bubbles.

## Interface
Parameters:
- `MRX_IND_WTH`, 5: matrix register index width.
- `MRX_ADDR_WTH`, 9: matrix register address width.
- `VR_IND_WTH`, 4: vector register index width.

Ports:
- `clk_i`, in, 1: single clock.
- `rst_n_i`, in, 1: reset, asynchronous, active-low.
- `desc_valid_i` / `desc_ready_o`, in / out, 1 / 1: descriptor handshake. Transfer when both are high at a rising edge.
- `desc_code_i`, in, 2: operation code, 1 = MMUL, 3 = MMAC.
- `desc_type_i`, in, 1: 0 = MM, 1 = VM.
- `desc_mpu0_sl_i`, `desc_mpu0_sr_i`, `desc_mpu1_sl_i`, `desc_mpu1_sr_i`, in, 1 each: shift-left / shift-right flags.
- `desc_mpu0_index_i`, `desc_mpu1_index_i`, `desc_mrs1_index_i`, in, MRX_IND_WTH: register indices.
- `desc_mpu0_addr_i`, `desc_mpu1_addr_i`, `desc_mrs1_addr_i`, in, MRX_ADDR_WTH: start addresses.
- `desc_stride_i`, in, MRX_ADDR_WTH: mrs0 address advance per repetition.
- `desc_vrd_index_i`, in, VR_IND_WTH: first destination vector register.
- `desc_mac_len_i`, in, 7: MMAC length in cycles.
- `desc_rep_i`, in, 8: number of commands to issue.
- `convctl_mpu__code_o`, `convctl_mpu__type_o`, `convctl_mpu0__mrs0_{sl,sr,index,addr}_o`, `convctl_mpu1__mrs0_{sl,sr,index,addr}_o`, `convctl_mpu__mrs1_{index,addr}_o`, out: presented command fields.
- `convctl_mpu__vrd_index_o`, out, VR_IND_WTH: executing-command destination index.
- `convctl_mpu__mac_len_o`, out, 7: executing-command length.
- `busy_o`, out, 1: issuer active.
- `done_o`, out, 1: one-cycle pulse when a descriptor completes.
- `err_o`, out, 1: one-cycle pulse when a descriptor is rejected.

## Operation
- FSM states:
  - S_IDLE: code output = 0.
  - S_ISSUE: presenting a command.
- Window length: MMAC = mac_len cycles; MMUL = 1 cycle.
- Each presented command is held constant for its whole window. `win_cnt` counts 0 to window−1.
- Last cycle of a window, with more reps remaining: the next rep starts on the following cycle.
  - mpu0/mpu1 mrs0 addr += stride, modulo 2^MRX_ADDR_WTH.
  - vrd_index += 1, modulo 2^VR_IND_WTH.
  - mrs1 addr, indices, sl/sr and type are unchanged.
- Last cycle of the last rep:
  - `done_o` = 1 and `desc_ready_o` = 1.
  - If a descriptor is accepted in that cycle, issue continues with no bubble.
  - Otherwise go to S_IDLE; all presented fields return to 0.
- `desc_ready_o` = (state == S_IDLE) or (last cycle of last rep). It is combinational.
- Illegal descriptors are accepted and dropped: `err_o` pulses on the next cycle, nothing is issued, and the state is S_IDLE.
  - code ∉ {1, 3}.
  - rep = 0.
  - MMAC with mac_len = 0.
- Execution-lag registers for `vrd_index_o` and `mac_len_o`:
  - Each loads the presented command's value one cycle after that command is first presented.
  - They hold until the next command's first cycle + 1.
  - This matches `mpu_ctrl`, which compares mac_len and captures vrd while executing, but samples the other fields at window boundaries.

## Timing
- Accept at edge c → command fields valid from c+1. Lag outputs valid from c+2.
- MMAC L: code = 3 for cycles c+1..c+L. The next command is presented at c+L+1.
- `busy_o` = 1 from c+1 through the last window cycle.
- Reset values: every output is 0, including code (IDLE), `busy_o`, `done_o` and `err_o`. `desc_ready_o` is 1.
- Reset asserted mid-operation: outputs clear asynchronously, the descriptor is discarded, and no `done_o` is produced.

## Structure
- Shared package `mpu_pkg`:
  - `MPU_CODE_MMUL` / `MPU_CODE_MMAC` constants.
  - EN_ACT / EN_MAC bit positions.
  - `MPU_TYPE_MM` / `MPU_TYPE_VM`.
  - `mpu_desc_t` struct holding the descriptor fields.
- Single module, no sub-module. It contains the descriptor register, rep counter, window counter, address/vrd incrementers and lag registers.

## Test plan
- **Single MMAC:** MMAC L=4, rep=1, mpu0 addr 0x10, mrs1 addr 0x20, vrd 3, accepted at edge c.
  - code = 3 for c+1..c+4; addresses stable.
  - `mac_len_o` = 4 and `vrd_index_o` = 3 over c+2..c+5.
  - `done_o` and `desc_ready_o` high at c+4; code = 0 at c+5.
- **Address and vrd wrap:** MMAC L=2, rep=3, stride 2, addr 0x1FE, vrd 14.
  - mrs0 addr sequence 0x1FE, 0x000, 0x002, two cycles each.
  - vrd sequence 14, 15, 0.
- **Repeated MMUL:** MMUL rep=4, vrd 0.
  - code = 1 for four consecutive cycles; vrd 0, 1, 2, 3.
  - `done_o` on the fourth cycle.
- **Back-to-back:** MMAC L=1 followed by an MMUL, with `desc_valid_i` held high.
  - No idle cycle between them.
  - `mac_len_o` = 1 during the MMAC execution cycle.
- **Illegal descriptors:** code = 2, then MMAC with mac_len = 0.
  - Each is accepted and `err_o` pulses once.
  - code stays 0, `busy_o` stays 0, no `done_o`.
- **Reset mid-operation:** assert `rst_n_i` low during rep 2 of 3.
  - All outputs 0 immediately.
  - After release: `desc_ready_o` = 1, no `done_o`, and a new descriptor issues normally.
